// File: rtl/pld_cfg_pkg.sv
// pld_cfg_pkg: shared types and sizes for the PLD configuration path
package pld_cfg_pkg;
  localparam int PLD_CFG_BYTES = 64;
  localparam int PLD_CONFIG_LEN = PLD_CFG_BYTES * 8;
  typedef enum logic [1:0] {IDLE, QUIESCE, COMMIT, RUN} state_t;
endpackage

// File: rtl/pld_cfg_shadow.sv
// pld_cfg_shadow: byte-addressable shadow image with written-mask and distinct-byte counter
module pld_cfg_shadow import pld_cfg_pkg::*; #(
  parameter int CFG_BYTES = PLD_CFG_BYTES,
  parameter int ADDR_W = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [7:0]             wr_data,
  input  logic                   clear,
  output logic [CFG_BYTES*8-1:0] shadow,
  output logic [ADDR_W:0]        bytes_loaded,
  output logic                   mask_full
);
  localparam logic [ADDR_W:0] FULL_CNT = CFG_BYTES[ADDR_W:0];
  localparam logic [ADDR_W:0] ONE = 1;
  logic [7:0] mem [CFG_BYTES];
  logic [CFG_BYTES-1:0] mask;
  logic hit, fresh;
  assign hit = wr_en && ({1'b0, wr_addr} < FULL_CNT);
  assign fresh = hit && !mask[wr_addr];
  // full including a write landing on this same edge, so a commit can ride along with the last byte
  assign mask_full = (bytes_loaded + (fresh ? ONE : '0)) == FULL_CNT;
  for (genvar i = 0; i < CFG_BYTES; i++) begin : g_pack
    assign shadow[i*8 +: 8] = mem[i];
  end
  // shadow bytes survive a commit; only reset clears them
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < CFG_BYTES; k++) mem[k] <= '0;
    end else if (hit) begin
      mem[wr_addr] <= wr_data;
    end
  end
  // mask and count track distinct bytes written since the last commit
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      mask <= '0;
      bytes_loaded <= '0;
    end else if (fresh) begin
      mask[wr_addr] <= 1'b1;
      bytes_loaded <= bytes_loaded + ONE;
    end
  end
endmodule

// File: rtl/pld_config_sequencer.sv
// pld_config_sequencer: atomic commit of a shadowed config image with pld_en quiesce sequencing
module pld_config_sequencer import pld_cfg_pkg::*; #(
  parameter int CFG_BYTES = PLD_CFG_BYTES,
  parameter int ADDR_W = 6,
  parameter int QUIESCE_CYCLES = 2,
  parameter int REQUIRE_FULL = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [7:0]             wr_data,
  input  logic                   commit_req,
  input  logic                   stop_req,
  output logic                   commit_ack,
  output logic                   commit_err,
  output logic [CFG_BYTES*8-1:0] pld_config,
  output logic                   pld_en,
  output logic                   busy,
  output logic [ADDR_W:0]        bytes_loaded
);
  localparam logic [3:0] Q_LAST = 4'(QUIESCE_CYCLES - 1);
  state_t state, state_nx;
  logic [3:0] q_cnt;
  logic [CFG_BYTES*8-1:0] shadow;
  logic mask_full, stop, commit, accept;
  assign wr_ready = state == IDLE || state == RUN;
  assign pld_en = state == RUN;
  assign busy = state == QUIESCE || state == COMMIT;
  pld_cfg_shadow #(.CFG_BYTES(CFG_BYTES), .ADDR_W(ADDR_W)) u_shadow (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_valid && wr_ready),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .clear(state == COMMIT),
    .shadow(shadow),
    .bytes_loaded(bytes_loaded),
    .mask_full(mask_full)
  );
  // stop beats commit; requests are only honoured while the write port is open
  always_comb begin
    stop = state == RUN && stop_req;
    commit = wr_ready && commit_req && !stop;
    accept = commit && (REQUIRE_FULL == 0 || mask_full);
    state_nx = stop ? IDLE :
               accept ? QUIESCE :
               state == QUIESCE ? (q_cnt == Q_LAST ? COMMIT : QUIESCE) :
               state == COMMIT ? RUN : state;
  end
  // state register and quiesce cycle counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      q_cnt <= '0;
    end else begin
      state <= state_nx;
      q_cnt <= state == QUIESCE ? q_cnt + 4'd1 : 4'd0;
    end
  end
  // image transfer at the end of COMMIT plus registered status pulses
  always_ff @(posedge clk) begin
    if (!reset) begin
      pld_config <= '0;
      commit_ack <= 1'b0;
      commit_err <= 1'b0;
    end else begin
      commit_ack <= state == COMMIT;
      commit_err <= commit && !accept;
      if (state == COMMIT) pld_config <= shadow;
    end
  end
endmodule
